// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared types, colour masks and timing helpers for the
//               video pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Runtime pattern selection; codes 5..7 are reserved and render black.
    typedef enum logic [2:0] {
        MODE_BAR   = 3'd0,
        MODE_GRID  = 3'd1,
        MODE_GRAD  = 3'd2,
        MODE_SOLID = 3'd3,
        MODE_BOX   = 3'd4
    } mode_e;

    // Colour-bar colours as {R,G,B} on/off masks, expanded to DATA_W later.
    localparam logic [2:0] c_mask_white   = 3'b111;
    localparam logic [2:0] c_mask_yellow  = 3'b110;
    localparam logic [2:0] c_mask_cyan    = 3'b011;
    localparam logic [2:0] c_mask_green   = 3'b010;
    localparam logic [2:0] c_mask_magenta = 3'b101;
    localparam logic [2:0] c_mask_red     = 3'b100;
    localparam logic [2:0] c_mask_blue    = 3'b001;
    localparam logic [2:0] c_mask_black   = 3'b000;

    localparam logic [2:0] c_last_bar = 3'd7;

    // Total period of a line or a frame.
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First counter value at which sync is asserted.
    function automatic int calc_sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First counter value at which sync is released again.
    function automatic int calc_sync_end(input int active, input int fp,
                                         input int sync);
        return active + fp + sync;
    endfunction

    // Bar index to colour mask: white, yellow, cyan, green, magenta, red,
    // blue, black.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = c_mask_white;
            3'd1:    m = c_mask_yellow;
            3'd2:    m = c_mask_cyan;
            3'd3:    m = c_mask_green;
            3'd4:    m = c_mask_magenta;
            3'd5:    m = c_mask_red;
            3'd6:    m = c_mask_blue;
            default: m = c_mask_black;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_core.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_core
// Description : Horizontal/vertical counters, sync/enable decode, colour-bar
//               index tracking and the registered frame-start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_core
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic [2:0]       o_bar_idx,
    output logic             o_frame_start_cond,
    output logic             o_de_cond,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_frame_start
);

    localparam int c_h_total = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_active   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_active   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(calc_sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(calc_sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(calc_sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(calc_sync_end(V_ACTIVE, V_FP, V_SYNC));
    // Bar width H_ACTIVE/8 is a constant, so the bar index is tracked with a
    // reloading down-counter rather than a runtime divide.
    localparam logic [CNT_W-1:0] c_bar_last   = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic             c_hs_on      = 1'(HS_POL);
    localparam logic             c_vs_on      = 1'(VS_POL);

    // r_active qualifies the counter state: it is low for the first enabled
    // edge so that (0,0) is established before it is presented.
    logic             r_active;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W-1:0] r_bar_cnt;
    logic [2:0]       r_bar_idx;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_fs;

    logic w_run;
    logic w_hs_on;
    logic w_vs_on;
    logic w_active;
    logic w_origin;

    assign w_run    = r_active & i_en;
    assign w_hs_on  = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs_on  = (r_v >= c_vs_start) && (r_v < c_vs_end);
    assign w_active = (r_h < c_h_active) && (r_v < c_v_active);
    assign w_origin = (r_h == '0) && (r_v == '0);

    assign o_h_cnt            = r_h;
    assign o_v_cnt            = r_v;
    assign o_bar_idx          = r_bar_idx;
    assign o_frame_start_cond = w_run & w_origin;
    assign o_de_cond          = w_run & w_active;
    assign o_hs               = r_hs;
    assign o_vs               = r_vs;
    assign o_de               = r_de;
    assign o_frame_start      = r_fs;

    // Advance counters while running and register the decoded timing outputs.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_active  <= 1'b0;
            r_h       <= '0;
            r_v       <= '0;
            r_bar_cnt <= c_bar_last;
            r_bar_idx <= 3'd0;
            r_hs      <= ~c_hs_on;
            r_vs      <= ~c_vs_on;
            r_de      <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (r_active) begin
                if (r_h == c_h_last) begin
                    r_h       <= '0;
                    r_bar_cnt <= c_bar_last;
                    r_bar_idx <= 3'd0;
                    r_v       <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                    if (r_bar_cnt == '0) begin
                        r_bar_cnt <= c_bar_last;
                        // Saturate so the last bar absorbs any remainder.
                        if (r_bar_idx != c_last_bar) begin
                            r_bar_idx <= r_bar_idx + 3'd1;
                        end
                    end else begin
                        r_bar_cnt <= r_bar_cnt - 1'b1;
                    end
                end
            end
            r_hs <= (r_active && w_hs_on) ? c_hs_on : ~c_hs_on;
            r_vs <= (r_active && w_vs_on) ? c_vs_on : ~c_vs_on;
            r_de <= r_active && w_active;
            r_fs <= r_active && w_origin;
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_gen
// Description : Parametrised video timing plus runtime-selectable test
//               patterns (colour bar, grid, gradient, solid, moving box).
// Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 12,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 4
) (
    input  logic                  pixel_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic [2:0]            mode,
    input  logic [3*DATA_W-1:0]   solid_rgb,
    output logic                  video_hs,
    output logic                  video_vs,
    output logic                  video_de,
    output logic [3*DATA_W-1:0]   video_rgb,
    output logic [CNT_W-1:0]      pixel_xpos,
    output logic [CNT_W-1:0]      pixel_ypos,
    output logic                  frame_start,
    output logic [15:0]           frame_cnt
);

    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic [2:0]       w_bar_idx;
    logic             w_fs_cond;
    logic             w_de_cond;

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk                (pixel_clk),
        .rst                (sys_rst),
        .i_en               (en),
        .o_h_cnt            (w_h),
        .o_v_cnt            (w_v),
        .o_bar_idx          (w_bar_idx),
        .o_frame_start_cond (w_fs_cond),
        .o_de_cond          (w_de_cond),
        .o_hs               (video_hs),
        .o_vs               (video_vs),
        .o_de               (video_de),
        .o_frame_start      (frame_start)
    );

    // Per-frame state, updated only on the frame-start edge.
    logic [2:0]          r_mode;
    logic [3*DATA_W-1:0] r_solid;
    logic [CNT_W-1:0]    r_box_x;
    logic [15:0]         r_frame_cnt;
    logic                r_first;
    logic [3*DATA_W-1:0] r_rgb;
    logic [CNT_W-1:0]    r_xpos;
    logic [CNT_W-1:0]    r_ypos;

    // The (0,0) pixel is rendered on the same edge that latches the frame
    // inputs, so the "current" values bypass the latches on that edge.
    logic [2:0]          w_mode_cur;
    logic [3*DATA_W-1:0] w_solid_cur;
    logic [CNT_W-1:0]    w_box_next;
    logic [CNT_W-1:0]    w_box_cur;
    logic [31:0]         w_box_sum;
    logic [31:0]         w_x32;
    logic [31:0]         w_y32;
    logic [31:0]         w_box32;
    logic                w_in_box;
    logic [3*DATA_W-1:0] w_pix;

    function automatic logic [3*DATA_W-1:0] expand_mask(input logic [2:0] m);
        return {{DATA_W{m[2]}}, {DATA_W{m[1]}}, {DATA_W{m[0]}}};
    endfunction

    assign w_box_sum  = 32'(r_box_x) + 32'(BOX_STEP) + 32'(BOX_SIZE);
    assign w_box_next = r_first                     ? '0 :
                        (w_box_sum > 32'(H_ACTIVE)) ? '0 :
                        CNT_W'(32'(r_box_x) + 32'(BOX_STEP));
    assign w_mode_cur  = w_fs_cond ? mode       : r_mode;
    assign w_solid_cur = w_fs_cond ? solid_rgb  : r_solid;
    assign w_box_cur   = w_fs_cond ? w_box_next : r_box_x;

    assign w_x32    = 32'(w_h);
    assign w_y32    = 32'(w_v);
    assign w_box32  = 32'(w_box_cur);
    assign w_in_box = (w_x32 >= w_box32) && (w_x32 < w_box32 + 32'(BOX_SIZE)) &&
                      (w_y32 < 32'(BOX_SIZE));

    // Pattern mux for the pixel at the current counter position.
    always_comb begin
        w_pix = '0;
        case (w_mode_cur)
            MODE_BAR:   w_pix = expand_mask(bar_mask(w_bar_idx));
            MODE_GRID:  w_pix = ((w_h[4:0] == 5'd0) || (w_v[4:0] == 5'd0)) ? '1 : '0;
            MODE_GRAD:  w_pix = {3{DATA_W'(w_h)}};
            MODE_SOLID: w_pix = w_solid_cur;
            MODE_BOX:   w_pix = w_in_box ? '1 : '0;
            default:    w_pix = '0;
        endcase
    end

    // Frame latch and registered pixel outputs.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            r_mode      <= 3'd0;
            r_solid     <= '0;
            r_box_x     <= '0;
            r_frame_cnt <= 16'd0;
            r_first     <= 1'b1;
            r_rgb       <= '0;
            r_xpos      <= '0;
            r_ypos      <= '0;
        end else begin
            if (w_fs_cond) begin
                r_mode      <= mode;
                r_solid     <= solid_rgb;
                r_box_x     <= w_box_next;
                r_first     <= 1'b0;
                r_frame_cnt <= r_first ? 16'd0 : r_frame_cnt + 16'd1;
            end
            r_rgb  <= w_de_cond ? w_pix : '0;
            r_xpos <= w_de_cond ? w_h   : '0;
            r_ypos <= w_de_cond ? w_v   : '0;
        end
    end

    assign video_rgb  = r_rgb;
    assign pixel_xpos = r_xpos;
    assign pixel_ypos = r_ypos;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_pattern_gen
// Description : Scoreboard bench for video_pattern_gen using a 16x8 active
//               raster (24x12 total).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_gen;

    logic        pixel_clk = 1'b0;
    logic        sys_rst;
    logic        en;
    logic [2:0]  mode;
    logic [23:0] solid_rgb;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;
    logic [11:0] pixel_xpos;
    logic [11:0] pixel_ypos;
    logic        frame_start;
    logic [15:0] frame_cnt;

    always #5 pixel_clk = ~pixel_clk;

    video_pattern_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1), .VS_POL (1), .DATA_W (8), .CNT_W (12),
        .BOX_SIZE (4), .BOX_STEP (4)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst     (sys_rst),
        .en          (en),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .video_rgb   (video_rgb),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
        logic        fs;
        logic [15:0] fc;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    // Hand-computed colour bar per x with 2-pixel bars.
    logic [23:0] bar_tbl [16] = '{
        24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
        24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
        24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
        24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge pixel_clk);
        #1;
    endtask

    // kind: 0 bar, 1 grid, 2 gradient, 3 solid 123456, 4 box, other black.
    task automatic push_frame(input int kind, input int box, input int fc, input int n_pix);
        for (int p = 0; p < n_pix; p++) begin
            int   x;
            int   y;
            pix_t e;
            x     = p % 16;
            y     = p / 16;
            e.x   = 12'(x);
            e.y   = 12'(y);
            e.fs  = (p == 0);
            e.fc  = 16'(fc);
            case (kind)
                0:       e.rgb = bar_tbl[x];
                1:       e.rgb = (x == 0 || y == 0) ? 24'hFFFFFF : 24'h000000;
                2:       e.rgb = {3{8'(x)}};
                3:       e.rgb = 24'h123456;
                4:       e.rgb = (x >= box && x < box + 4 && y < 4) ? 24'hFFFFFF : 24'h000000;
                default: e.rgb = 24'h000000;
            endcase
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expectation per active pixel; blanking must be clean.
    initial begin
        pix_t e;
        wait (mon_en);
        forever begin
            @(negedge pixel_clk);
            if (video_de === 1'b1) begin
                chk("de_sync_overlap", {30'd0, video_hs, video_vs}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got pixel (%0d,%0d) expected none at %0t",
                             pixel_xpos, pixel_ypos, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_x",   32'(pixel_xpos),  32'(e.x));
                    chk("pix_y",   32'(pixel_ypos),  32'(e.y));
                    chk("pix_rgb", 32'(video_rgb),   32'(e.rgb));
                    chk("pix_fs",  32'(frame_start), 32'(e.fs));
                    chk("pix_fc",  32'(frame_cnt),   32'(e.fc));
                end
            end else begin
                chk("blank_rgb", 32'(video_rgb), 32'd0);
                chk("blank_pos", {8'd0, pixel_xpos, pixel_ypos}, 32'd0);
                chk("blank_fs",  32'(frame_start), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int hs_first;
        int hs_line0;
        int vs_first;
        int vs_cnt;
        int de_cnt;
        int de_line0;
        int fs_cnt;
        int kinds [8] = '{4, 4, 4, 4, 4, 2, 1, 5};
        int boxes [8] = '{0, 4, 8, 12, 0, 0, 0, 0};
        int modes [8] = '{4, 4, 4, 4, 4, 2, 1, 5};

        hs_first = -1; hs_line0 = 0; vs_first = -1; vs_cnt = 0;
        de_cnt = 0; de_line0 = 0; fs_cnt = 0;

        sys_rst = 1'b1; en = 1'b1; mode = 3'd0; solid_rgb = 24'h0;
        repeat (3) tick;
        chk("rst_hs",   32'(video_hs),    32'd0);
        chk("rst_vs",   32'(video_vs),    32'd0);
        chk("rst_de",   32'(video_de),    32'd0);
        chk("rst_rgb",  32'(video_rgb),   32'd0);
        chk("rst_pos",  {8'd0, pixel_xpos, pixel_ypos}, 32'd0);
        chk("rst_fs",   32'(frame_start), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt),   32'd0);
        mon_en = 1'b1;

        // Frame 0 colour bars, then frame 1 solid after a mid-frame switch.
        push_frame(0, 0, 0, 128);
        push_frame(3, 0, 1, 128);
        sys_rst = 1'b0;
        tick;
        chk("rel_edge1_de", 32'(video_de), 32'd0);
        tick;
        chk("rel_edge2_de", 32'(video_de),    32'd1);
        chk("rel_edge2_fs", 32'(frame_start), 32'd1);

        for (int k = 0; k < 288; k++) begin
            if (video_hs) begin
                if (hs_first < 0) hs_first = k;
                if (k < 24) hs_line0++;
            end
            if (video_vs) begin
                if (vs_first < 0) vs_first = k;
                vs_cnt++;
            end
            if (video_de) begin
                de_cnt++;
                if (k < 24) de_line0++;
            end
            if (frame_start) fs_cnt++;
            if (k == 72) begin
                mode      = 3'd3;
                solid_rgb = 24'h123456;
            end
            tick;
        end
        chk("fs_period",   32'(frame_start), 32'd1);
        chk("fcnt_f1",     32'(frame_cnt),   32'd1);
        chk("hs_offset",   32'(hs_first),    32'd18);
        chk("hs_width",    32'(hs_line0),    32'd3);
        chk("vs_offset",   32'(vs_first),    32'd216);
        chk("vs_width",    32'(vs_cnt),      32'd48);
        chk("de_per_line", 32'(de_line0),    32'd16);
        chk("de_per_frm",  32'(de_cnt),      32'd128);
        chk("fs_per_frm",  32'(fs_cnt),      32'd1);

        // Frame 2: abort with en low at pixel (5,5).
        push_frame(3, 0, 2, 86);
        repeat (288) tick;
        chk("f2_fs",   32'(frame_start), 32'd1);
        chk("f2_fcnt", 32'(frame_cnt),   32'd2);
        repeat (125) tick;
        chk("abort_pre_de", 32'(video_de),   32'd1);
        chk("abort_pre_x",  32'(pixel_xpos), 32'd5);
        en = 1'b0;
        tick;
        chk("abort_de",    32'(video_de),  32'd0);
        chk("abort_hs",    32'(video_hs),  32'd0);
        chk("abort_vs",    32'(video_vs),  32'd0);
        chk("abort_rgb",   32'(video_rgb), 32'd0);
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        repeat (3) tick;
        chk("hold_fcnt", 32'(frame_cnt), 32'd2);

        // Re-enable: frame 3 continues the count; reset pulse at (19,2).
        push_frame(3, 0, 3, 48);
        en = 1'b1;
        tick;
        chk("reen_edge1_de", 32'(video_de), 32'd0);
        tick;
        chk("reen_fs",   32'(frame_start), 32'd1);
        chk("reen_fcnt", 32'(frame_cnt),   32'd3);
        repeat (2 * 24 + 19) tick;
        chk("rst_pre_hs", 32'(video_hs), 32'd1);
        sys_rst = 1'b1;
        mode    = 3'd4;
        tick;
        chk("rst_abort_hs",    32'(video_hs),  32'd0);
        chk("rst_abort_de",    32'(video_de),  32'd0);
        chk("rst_abort_rgb",   32'(video_rgb), 32'd0);
        chk("rst_abort_fcnt",  32'(frame_cnt), 32'd0);
        chk("rst_abort_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) tick;

        // Moving box frames 0..4 (wrap on frame 4), then gradient, grid, reserved.
        for (int f = 0; f < 8; f++) push_frame(kinds[f], boxes[f], f, 128);
        sys_rst = 1'b0;
        tick;
        chk("b_edge1_de", 32'(video_de), 32'd0);
        tick;
        chk("b_fs0",   32'(frame_start), 32'd1);
        chk("b_fcnt0", 32'(frame_cnt),   32'd0);
        for (int f = 1; f < 8; f++) begin
            mode = 3'(modes[f]);
            repeat (288) tick;
            chk("b_fs",   32'(frame_start), 32'd1);
            chk("b_fcnt", 32'(frame_cnt),   32'(f));
        end
        repeat (200) tick;
        en = 1'b0;
        tick;
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
